tile_board_writer: RTL and testbench

Consumer end of the game-logic output interface. Samples falling-piece positions, previous positions, piece colour and row-clear commands once per frame. Applies them as write sequences to the on-chip tile RAM: 10x20 entries of 16-bit colour, read by the VGA color mapper. Owns every tile RAM write; game logic never touches video memory.

---
 rtl/tetris_pkg.sv | 23 ++
 rtl/tile_board_writer_if.sv | 41 ++++
 rtl/tile_board_writer_addr_calc.sv | 25 ++
 rtl/tile_board_writer.sv | 215 +++++++++++++++++++++
 tb/tb_tile_board_writer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared board geometry, tile types and writer state encoding.
// Latency: none (declarations only).
// Backpressure: none.
package tetris_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;

    typedef logic [6:0]  coord_t;
    typedef logic [15:0] color_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_ERASE,
        ST_SHIFT_RD,
        ST_SHIFT_WR,
        ST_FILL,
        ST_DRAW,
        ST_DONE
    } writer_state_t;

endpackage

// File: rtl/tile_board_writer_if.sv
// Game-logic frame inputs plus the tile RAM read/write port and status strobes.
// Latency: none (wiring only).
// Backpressure: none; the writer signals activity through busy/frame_overrun.
interface tile_board_writer_if #(
    parameter int ADDR_W = 8
) ();
    import tetris_pkg::*;

    logic                  frame_clk;
    coord_t [3:0]          blockXPos;
    coord_t [3:0]          blockYPos;
    coord_t [3:0]          blockXPrev;
    coord_t [3:0]          blockYPrev;
    color_t                blockColor;
    logic                  Clear_row;
    logic [3:0]            Num_rows_to_clear;
    coord_t                Row_to_clear;
    logic [ADDR_W-1:0]     tile_raddr;
    color_t                tile_rdata;
    logic                  tile_we;
    logic [ADDR_W-1:0]     tile_waddr;
    color_t                tile_wdata;
    logic                  busy;
    logic                  frame_done;
    logic                  frame_overrun;

    // The board writer consumes frame inputs and owns the RAM port.
    modport slave (
        input  frame_clk, blockXPos, blockYPos, blockXPrev, blockYPrev,
        input  blockColor, Clear_row, Num_rows_to_clear, Row_to_clear, tile_rdata,
        output tile_raddr, tile_we, tile_waddr, tile_wdata, busy, frame_done, frame_overrun
    );

    // The game/RAM side drives frame inputs and returns read data.
    modport master (
        output frame_clk, blockXPos, blockYPos, blockXPrev, blockYPrev,
        output blockColor, Clear_row, Num_rows_to_clear, Row_to_clear, tile_rdata,
        input  tile_raddr, tile_we, tile_waddr, tile_wdata, busy, frame_done, frame_overrun
    );

endinterface

// File: rtl/tile_board_writer_addr_calc.sv
// Tile coordinate to linear RAM address, with on-board range flag.
// Latency: combinational.
// Backpressure: none.
module tile_addr_calc
    import tetris_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  coord_t            x,
    input  coord_t            y,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    logic [ADDR_W-1:0] xw;
    logic [ADDR_W-1:0] yw;

    assign xw = ADDR_W'(x);
    assign yw = ADDR_W'(y);

    // y*10 as two shifts and an add keeps this a pure adder tree.
    assign addr     = (yw << 3) + (yw << 1) + xw;
    assign in_range = (x < 7'(BOARD_W)) && (y < 7'(BOARD_H));

endmodule

// File: rtl/tile_board_writer.sv
// Applies one frame of piece erase / row shift / fill / draw writes to tile RAM; CLEAR_SCREEN_ON_RESET_EN adds a post-reset screen wipe.
// Latency: 10 cycles edge-to-done for a move frame, 1+20*(R-N+1)+10*N+5 for a clear frame.
// Backpressure: none; a frame edge arriving while busy is dropped and flagged on frame_overrun.
module tile_board_writer
    import tetris_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [15:0] BG_COLOR = 16'h0000
) (
    input  logic               Clk,
    input  logic               Reset,
    tile_board_writer_if.slave bus
);

`ifdef CLEAR_SCREEN_ON_RESET_EN
    localparam writer_state_t RESET_STATE = ST_INIT;
    logic [ADDR_W-1:0] init_addr, init_nxt;
`else
    localparam writer_state_t RESET_STATE = ST_IDLE;
`endif

    writer_state_t     state, state_nxt, after_erase;
    coord_t [3:0]      pos_x, pos_y, prev_x, prev_y;
    color_t            color_q;
    logic              clear_q;
    logic [3:0]        nrows_q;
    coord_t            rrow_q;
    logic              frame_q, frame_rise, overrun_q;
    logic [1:0]        slot, slot_nxt;
    logic [3:0]        col, col_nxt;
    coord_t            row, row_nxt, first_row;
    logic              sel_clear, shift_go;
    logic [3:0]        sel_n;
    coord_t            sel_r;
    coord_t            calc_x, calc_y;
    logic [ADDR_W-1:0] calc_addr, raddr_q, raddr_out, waddr;
    logic              calc_ok, we, rd, done;
    color_t            wdata;

    tile_addr_calc #(.ADDR_W(ADDR_W)) u_addr (
        .x(calc_x), .y(calc_y), .addr(calc_addr), .in_range(calc_ok)
    );

    assign frame_rise = bus.frame_clk & ~frame_q;

    // In IDLE the snapshot is being loaded this cycle, so decide the path from the live inputs.
    assign sel_clear   = (state == ST_IDLE) ? bus.Clear_row         : clear_q;
    assign sel_n       = (state == ST_IDLE) ? bus.Num_rows_to_clear : nrows_q;
    assign sel_r       = (state == ST_IDLE) ? bus.Row_to_clear      : rrow_q;
    assign shift_go    = sel_clear && (sel_n != 4'd0) && (sel_n <= 4'd4) && (sel_r < 7'(BOARD_H));
    assign after_erase = !shift_go ? ST_DRAW : (sel_r >= {3'b0, sel_n}) ? ST_SHIFT_RD : ST_FILL;
    assign first_row   = (after_erase == ST_SHIFT_RD) ? sel_r : ({3'b0, sel_n} - 7'd1);

    // State and sequencing counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= RESET_STATE;
            slot  <= 2'd0;
            col   <= 4'd0;
            row   <= 7'd0;
        end else begin
            state <= state_nxt;
            slot  <= slot_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
        end
    end

`ifdef CLEAR_SCREEN_ON_RESET_EN
    // Wipe address counter, restarted by every reset.
    always_ff @(posedge Clk) begin
        if (Reset) init_addr <= '0;
        else       init_addr <= init_nxt;
    end
`endif

    // Frame inputs are captured once, on an accepted edge, and held for the whole sequence.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pos_x <= '0; pos_y <= '0; prev_x <= '0; prev_y <= '0;
            color_q <= '0; clear_q <= 1'b0; nrows_q <= '0; rrow_q <= '0;
        end else if (frame_rise && state == ST_IDLE) begin
            pos_x   <= bus.blockXPos;  pos_y  <= bus.blockYPos;
            prev_x  <= bus.blockXPrev; prev_y <= bus.blockYPrev;
            color_q <= bus.blockColor; clear_q <= bus.Clear_row;
            nrows_q <= bus.Num_rows_to_clear; rrow_q <= bus.Row_to_clear;
        end
    end

    // Edge detector is primed during reset so a high frame_clk is not seen as a new edge.
    always_ff @(posedge Clk) begin
        frame_q <= bus.frame_clk;
        if (Reset) begin
            overrun_q <= 1'b0;
            raddr_q   <= '0;
        end else begin
            overrun_q <= frame_rise && (state != ST_IDLE);
            raddr_q   <= raddr_out;
        end
    end

    // Next state, counters and RAM port for the current phase.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        col_nxt   = col;
        row_nxt   = row;
        calc_x    = '0;
        calc_y    = '0;
        we        = 1'b0;
        rd        = 1'b0;
        done      = 1'b0;
        waddr     = calc_addr;
        wdata     = '0;
`ifdef CLEAR_SCREEN_ON_RESET_EN
        init_nxt  = init_addr;
`endif
        case (state)
            ST_IDLE: begin
                waddr = '0;
                if (frame_rise) begin
                    // Lock frames carry stale previous positions, so they skip ERASE.
                    state_nxt = sel_clear ? after_erase : ST_ERASE;
                    row_nxt   = first_row;
                    col_nxt   = 4'd0;
                end
            end
`ifdef CLEAR_SCREEN_ON_RESET_EN
            ST_INIT: begin
                we       = 1'b1;
                waddr    = init_addr;
                wdata    = BG_COLOR;
                init_nxt = init_addr + 1'b1;
                if (init_addr == ADDR_W'(BOARD_W * BOARD_H - 1)) state_nxt = ST_IDLE;
            end
`endif
            ST_ERASE: begin
                calc_x   = prev_x[slot];
                calc_y   = prev_y[slot];
                we       = calc_ok;
                wdata    = BG_COLOR;
                slot_nxt = slot + 2'd1;
                if (slot == 2'd3) begin
                    state_nxt = after_erase;
                    row_nxt   = first_row;
                    col_nxt   = 4'd0;
                end
            end
            ST_SHIFT_RD: begin
                calc_x    = {3'b0, col};
                calc_y    = row - {3'b0, nrows_q};
                rd        = 1'b1;
                waddr     = '0;
                state_nxt = ST_SHIFT_WR;
            end
            ST_SHIFT_WR: begin
                calc_x    = {3'b0, col};
                calc_y    = row;
                we        = 1'b1;
                wdata     = bus.tile_rdata;
                state_nxt = ST_SHIFT_RD;
                col_nxt   = col + 4'd1;
                if (col == 4'(BOARD_W - 1)) begin
                    col_nxt = 4'd0;
                    if (row == {3'b0, nrows_q}) begin
                        state_nxt = ST_FILL;
                        row_nxt   = {3'b0, nrows_q} - 7'd1;
                    end else begin
                        row_nxt   = row - 7'd1;
                    end
                end
            end
            ST_FILL: begin
                calc_x  = {3'b0, col};
                calc_y  = row;
                we      = 1'b1;
                wdata   = BG_COLOR;
                col_nxt = col + 4'd1;
                if (col == 4'(BOARD_W - 1)) begin
                    col_nxt = 4'd0;
                    if (row == 7'd0) state_nxt = ST_DRAW;
                    else             row_nxt   = row - 7'd1;
                end
            end
            ST_DRAW: begin
                calc_x   = pos_x[slot];
                calc_y   = pos_y[slot];
                we       = calc_ok;
                wdata    = color_q;
                slot_nxt = slot + 2'd1;
                if (slot == 2'd3) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                waddr     = '0;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                waddr     = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reset silences the RAM port in the very cycle it is asserted.
    assign raddr_out         = (rd && !Reset) ? calc_addr : raddr_q;
    assign bus.tile_raddr    = raddr_out;
    assign bus.tile_we       = we & ~Reset;
    assign bus.tile_waddr    = waddr;
    assign bus.tile_wdata    = wdata;
    assign bus.busy          = (state != ST_IDLE) & ~Reset;
    assign bus.frame_done    = done & ~Reset;
    assign bus.frame_overrun = overrun_q;

endmodule

// File: tb/tb_tile_board_writer.sv
// Self-checking bench: tile RAM model, board-level reference model, directed and random frames.
// Latency: checks edge-to-frame_done cycle counts against closed-form frame lengths.
// Backpressure: exercises dropped frame edges and reset during a sequence.
module tb_tile_board_writer;
    import tetris_pkg::*;

    localparam int          AW = 8;
    localparam logic [15:0] BG = 16'h0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tile_board_writer_if #(.ADDR_W(AW)) bus ();
    tile_board_writer #(.ADDR_W(AW), .BG_COLOR(BG)) dut (.Clk(clk), .Reset(rst), .bus(bus));

    logic [15:0] ram     [256];
    logic [15:0] exp_ram [256];
    logic        preload;
    int          wr_addr_q [$];
    int          wr_data_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          px[4], py[4], qx[4], qy[4];
    logic [15:0] pcol;
    bit          clr;
    int          nr, rr;
    int          exp_cycles, exp_writes;

    // Synchronous tile RAM with one-cycle read latency; logs every write.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= 16'(i);
        end else if (bus.tile_we) begin
            ram[bus.tile_waddr] <= bus.tile_wdata;
            wr_addr_q.push_back(int'(bus.tile_waddr));
            wr_data_q.push_back(int'(bus.tile_wdata));
        end
        bus.tile_rdata <= ram[bus.tile_raddr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit on_board(input int x, input int y);
        return x >= 0 && x < 10 && y >= 0 && y < 20;
    endfunction

    // Expected board after one frame, derived from the current RAM contents.
    task automatic model_frame();
        bit go;
        int rows;
        for (int a = 0; a < 256; a++) exp_ram[a] = ram[a];
        exp_writes = 0;
        if (!clr)
            for (int i = 0; i < 4; i++)
                if (on_board(qx[i], qy[i])) begin
                    exp_ram[qy[i] * 10 + qx[i]] = BG;
                    exp_writes++;
                end
        go   = clr && nr >= 1 && nr <= 4 && rr < 20;
        rows = (go && rr >= nr) ? rr - nr + 1 : 0;
        if (go) begin
            for (int r = nr; r <= rr; r++)
                for (int c = 0; c < 10; c++) exp_ram[r * 10 + c] = ram[(r - nr) * 10 + c];
            for (int r = 0; r < nr; r++)
                for (int c = 0; c < 10; c++) exp_ram[r * 10 + c] = BG;
            exp_writes += 10 * rows + 10 * nr;
        end
        for (int i = 0; i < 4; i++)
            if (on_board(px[i], py[i])) begin
                exp_ram[py[i] * 10 + px[i]] = pcol;
                exp_writes++;
            end
        if (!clr)    exp_cycles = 10;
        else if (go) exp_cycles = 1 + 20 * rows + 10 * nr + 4 + 1;
        else         exp_cycles = 6;
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < 4; i++) begin
            bus.blockXPos[i]  = 7'(px[i]);
            bus.blockYPos[i]  = 7'(py[i]);
            bus.blockXPrev[i] = 7'(qx[i]);
            bus.blockYPrev[i] = 7'(qy[i]);
        end
        bus.blockColor        = pcol;
        bus.Clear_row         = clr;
        bus.Num_rows_to_clear = 4'(nr);
        bus.Row_to_clear      = 7'(rr);
    endtask

    // One frame: cycle 1 is the cycle in which the rising frame_clk is sampled.
    task automatic run_frame(input int ovr_at, input string tag);
        int n, done_at, ovr, start, mism;
        start = wr_addr_q.size();
        model_frame();
        apply_inputs();
        bus.frame_clk = 1'b1;
        n = 0; done_at = 0; ovr = 0;
        while (done_at == 0 && n < 2000) begin
            tick();
            n++;
            if (n == 1) check({tag, "_busy_start"}, bus.busy, 1);
            if (n == 2) bus.frame_clk = 1'b0;
            if (ovr_at != 0 && n == ovr_at) bus.frame_clk = 1'b1;
            if (ovr_at != 0 && n == ovr_at + 2) bus.frame_clk = 1'b0;
            if (bus.frame_overrun) ovr++;
            if (bus.frame_done) done_at = n + 1;
        end
        check({tag, "_cycles"}, done_at, exp_cycles);
        check({tag, "_overrun"}, ovr, (ovr_at != 0) ? 1 : 0);
        tick();
        check({tag, "_done_width"}, bus.frame_done, 0);
        check({tag, "_busy_end"}, bus.busy, 0);
        check({tag, "_writes"}, wr_addr_q.size() - start, exp_writes);
        mism = 0;
        for (int a = 0; a < 256; a++) if (ram[a] !== exp_ram[a]) mism++;
        check({tag, "_ram"}, mism, 0);
    endtask

    initial begin
        int we_hi, busy_hi, done_hi, s;
        int e_a[8];
        bus.frame_clk = 1'b0;
        px = '{0, 0, 0, 0}; py = '{0, 0, 0, 0}; qx = '{0, 0, 0, 0}; qy = '{0, 0, 0, 0};
        pcol = '0; clr = 1'b0; nr = 0; rr = 0;
        apply_inputs();
        rst = 1'b1;
        preload = 1'b1;
        repeat (3) tick();
        preload = 1'b0;
        rst = 1'b0;
        tick();
        check("rst_we", bus.tile_we, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.frame_done, 0);
        check("rst_overrun", bus.frame_overrun, 0);
        check("rst_waddr", bus.tile_waddr, 0);
        check("rst_wdata", bus.tile_wdata, 0);
        check("rst_raddr", bus.tile_raddr, 0);

        we_hi = 0; busy_hi = 0; done_hi = 0;
        repeat (50) begin
            tick();
            if (bus.tile_we)    we_hi++;
            if (bus.busy)       busy_hi++;
            if (bus.frame_done) done_hi++;
        end
        check("idle_we", we_hi, 0);
        check("idle_busy", busy_hi, 0);
        check("idle_done", done_hi, 0);

        // Move frame: piece falls one row.
        qx = '{4, 5, 5, 6}; qy = '{0, 0, 1, 1};
        px = '{4, 5, 5, 6}; py = '{1, 1, 2, 2};
        pcol = 16'h0f00; clr = 1'b0;
        s = wr_addr_q.size();
        run_frame(0, "move");
        e_a = '{4, 5, 15, 16, 14, 15, 25, 26};
        if (wr_addr_q.size() - s >= 8)
            for (int i = 0; i < 8; i++) begin
                check($sformatf("move_seq_addr%0d", i), wr_addr_q[s + i], e_a[i]);
                check($sformatf("move_seq_data%0d", i), wr_data_q[s + i], (i < 4) ? 32'(BG) : 32'h0f00);
            end

        // Slot 3 lands off the right edge.
        qx = px; qy = py;
        px = '{1, 2, 3, 10}; py = '{5, 5, 5, 5}; pcol = 16'h1234;
        run_frame(0, "oob");

        // Second edge arrives 5 cycles into the sequence.
        qx = px; qy = py;
        px = '{1, 2, 3, 4}; py = '{6, 6, 6, 6}; pcol = 16'h0abc;
        run_frame(5, "overrun");

        // Single-row clear with RAM holding its own addresses.
        preload = 1'b1; tick(); preload = 1'b0; tick();
        clr = 1'b1; nr = 1; rr = 18;
        px = '{3, 4, 3, 4}; py = '{10, 10, 11, 11}; pcol = 16'h00f0;
        run_frame(0, "clear");
        check("clear_row18", ram[185], 175);
        check("clear_row1", ram[10], 0);
        check("clear_row0", ram[7], BG);
        check("clear_row19", ram[195], 195);

        // Reset in the middle of the row shift.
        clr = 1'b1; nr = 2; rr = 18;
        model_frame();
        apply_inputs();
        bus.frame_clk = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 2) bus.frame_clk = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("abort_we_now", bus.tile_we, 0);
        check("abort_busy_now", bus.busy, 0);
        s = wr_addr_q.size();
        tick();
        check("abort_we_1", bus.tile_we, 0);
        tick();
        check("abort_we_2", bus.tile_we, 0);
        check("abort_writes", wr_addr_q.size() - s, 0);
        rst = 1'b0;
        tick();
        check("abort_busy_after", bus.busy, 0);

        // Reset and frame edge together: the edge is swallowed.
        rst = 1'b1; bus.frame_clk = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("rst_edge_busy", bus.busy, 0);
        bus.frame_clk = 1'b0;
        tick();

        clr = 1'b0; nr = 0; rr = 0;
        qx = '{0, 0, 0, 0}; qy = '{0, 0, 0, 0};
        px = '{7, 8, 8, 9}; py = '{3, 3, 4, 4}; pcol = 16'h5a5a;
        run_frame(0, "post_abort");

        // Random frames.
        for (int f = 0; f < 20; f++) begin
            clr = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 4; i++) begin
                qx[i] = px[i]; qy[i] = py[i];
                px[i] = $urandom_range(0, 11);
                py[i] = $urandom_range(0, 21);
            end
            pcol = 16'($urandom);
            nr   = $urandom_range(0, 5);
            rr   = (nr >= 1 && nr <= 4) ? $urandom_range(nr, 21) : $urandom_range(0, 21);
            run_frame(0, $sformatf("rand%0d", f));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
